analog_io_seq: RTL and testbench

Transaction sequencer that drives the enable/direction/data side of the analog I/O port block. Accepts single write or read requests over a valid/ready handshake, sequences the port's enable and direction with a bus-turnaround cycle and settle delay, and returns read samples as a one-cycle response pulse. Sits between the control logic and the analog I/O port instance.

---
 rtl/analog_io_pkg.sv | 18 +
 rtl/analog_io_seq_if.sv | 28 ++
 rtl/analog_io_acc.sv | 26 ++
 rtl/analog_io_seq.sv | 183 ++++++++++++++++++
 tb/tb_analog_io_seq.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/analog_io_pkg.sv
// Shared state type and fixed timing constants for the analog I/O transaction sequencer.
package analog_io_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StTurn,
        StWrite,
        StRead,
        StCapt,
        StDone
    } state_e;

    localparam int unsigned N_AVG        = 4;
    localparam int unsigned AVG_SHIFT    = 2;
    localparam int unsigned TURN_CYCLES  = 1;
    localparam int unsigned WRITE_CYCLES = 2;

endpackage

// File: rtl/analog_io_seq_if.sv
// Request/response handshake plus port-block enable/direction/data bundle for analog_io_seq.
interface analog_io_seq_if #(
    parameter int unsigned BITS = 16
);
    logic            req_valid;
    logic            req_ready;
    logic            req_write;
    logic [BITS-1:0] req_data;
    logic            rsp_valid;
    logic [BITS-1:0] rsp_data;
    logic            busy;
    logic            io_en;
    logic            io_dir;
    logic [BITS-1:0] io_wdata;
    logic [BITS-1:0] io_rdata;

    // Control logic and port block side.
    modport master (
        output req_valid, req_write, req_data, io_rdata,
        input  req_ready, rsp_valid, rsp_data, busy, io_en, io_dir, io_wdata
    );

    // Sequencer side.
    modport slave (
        input  req_valid, req_write, req_data, io_rdata,
        output req_ready, rsp_valid, rsp_data, busy, io_en, io_dir, io_wdata
    );
endinterface

// File: rtl/analog_io_acc.sv
// Sample accumulator for read averaging: clear, add one sample per cycle, expose running total.
module analog_io_acc #(
    parameter int unsigned BITS = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            add,
    input  logic [BITS-1:0] din,
    output logic [BITS+1:0] total
);
    logic [BITS+1:0] acc_q;

    // Total includes the sample presented this cycle so the last add can be consumed directly.
    assign total = acc_q + {2'b00, din};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (clear) begin
            acc_q <= '0;
        end else if (add) begin
            acc_q <= total;
        end
    end
endmodule

// File: rtl/analog_io_seq.sv
// Write/read transaction sequencer for the analog I/O port block with bus turnaround.
// Define IO_SEQ_AVG_EN to average four captured samples per read.
module analog_io_seq
    import analog_io_pkg::*;
#(
    parameter int unsigned BITS   = 16,
    parameter int unsigned SETTLE = 2
) (
    input logic            clk,
    input logic            rst_n,
    analog_io_seq_if.slave bus
);
    localparam int unsigned CW = $clog2(SETTLE + 2);

    localparam logic [CW-1:0] TURN_LAST  = CW'(TURN_CYCLES - 1);
    localparam logic [CW-1:0] WRITE_LAST = CW'(WRITE_CYCLES - 1);
    localparam logic [CW-1:0] READ_LAST  = CW'(SETTLE);
`ifdef IO_SEQ_AVG_EN
    localparam logic [CW-1:0] CAPT_LAST  = CW'(N_AVG - 1);
    localparam logic          CAPT_EN    = 1'b1;
`else
    localparam logic [CW-1:0] CAPT_LAST  = '0;
    localparam logic          CAPT_EN    = 1'b0;
`endif

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            last_dir_q, last_dir_d;
    logic            write_q, write_d;
    logic [BITS-1:0] data_q, data_d;
    logic [BITS-1:0] io_wdata_q, io_wdata_d;
    logic [BITS-1:0] rsp_data_q, rsp_data_d;
    logic [BITS-1:0] capt_sample;

    logic            req_ready;
    logic            rsp_valid;
    logic            io_en;
    logic            io_dir;

`ifdef IO_SEQ_AVG_EN
    logic            acc_clear;
    logic            acc_add;
    logic [BITS+1:0] acc_total;

    analog_io_acc #(
        .BITS (BITS)
    ) u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (acc_clear),
        .add   (acc_add),
        .din   (bus.io_rdata),
        .total (acc_total)
    );

    assign capt_sample = acc_total[AVG_SHIFT +: BITS];
`else
    assign capt_sample = bus.io_rdata;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CW'(1);
        last_dir_d = last_dir_q;
        write_d    = write_q;
        data_d     = data_q;
        io_wdata_d = io_wdata_q;
        rsp_data_d = rsp_data_q;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        io_en      = 1'b0;
        io_dir     = last_dir_q;
`ifdef IO_SEQ_AVG_EN
        acc_clear  = 1'b0;
        acc_add    = 1'b0;
`endif

        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                cnt_d     = '0;
                if (bus.req_valid) begin
                    write_d = bus.req_write;
                    data_d  = bus.req_data;
                    if (bus.req_write != last_dir_q) begin
                        state_d = StTurn;
                    end else if (bus.req_write) begin
                        state_d    = StWrite;
                        io_wdata_d = bus.req_data;
                    end else begin
                        state_d = StRead;
                    end
                end
            end

            // Dead cycle with the port disabled so the pin never sees both drivers.
            StTurn: begin
                if (cnt_q == TURN_LAST) begin
                    cnt_d = '0;
                    if (write_q) begin
                        state_d    = StWrite;
                        io_wdata_d = data_q;
                    end else begin
                        state_d = StRead;
                    end
                end
            end

            StWrite: begin
                io_en      = 1'b1;
                io_dir     = 1'b1;
                last_dir_d = 1'b1;
                if (cnt_q == WRITE_LAST) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end

            StRead: begin
                io_en      = 1'b1;
                io_dir     = 1'b0;
                last_dir_d = 1'b0;
`ifdef IO_SEQ_AVG_EN
                acc_clear  = 1'b1;
`endif
                if (cnt_q == READ_LAST) begin
                    cnt_d   = '0;
                    state_d = StCapt;
                end
            end

            StCapt: begin
                io_en  = CAPT_EN;
                io_dir = 1'b0;
`ifdef IO_SEQ_AVG_EN
                acc_add = 1'b1;
`endif
                if (cnt_q == CAPT_LAST) begin
                    cnt_d      = '0;
                    state_d    = StDone;
                    rsp_data_d = capt_sample;
                end
            end

            StDone: begin
                rsp_valid = 1'b1;
                state_d   = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            last_dir_q <= 1'b0;
            write_q    <= 1'b0;
            data_q     <= '0;
            io_wdata_q <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_dir_q <= last_dir_d;
            write_q    <= write_d;
            data_q     <= data_d;
            io_wdata_q <= io_wdata_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.io_en     = io_en;
    assign bus.io_dir    = io_dir;
    assign bus.io_wdata  = io_wdata_q;
endmodule

// File: tb/tb_analog_io_seq.sv
// Scoreboard bench for analog_io_seq: write/read sequencing, turnaround, reset abort, hold-off.
module tb_analog_io_seq;
    import analog_io_pkg::*;

    localparam int unsigned BITS   = 16;
    localparam int unsigned SETTLE = 2;
`ifdef IO_SEQ_AVG_EN
    localparam int AVG_EXTRA = 3;
`else
    localparam int AVG_EXTRA = 0;
`endif
    localparam int PERIOD_RD = SETTLE + 4 + AVG_EXTRA;

    logic clk;
    logic rst_n;

    analog_io_seq_if #(.BITS(BITS)) bus ();

    analog_io_seq #(
        .BITS   (BITS),
        .SETTLE (SETTLE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_acc    = 0;
    int n_rsp    = 0;
    logic [BITS-1:0] sb_q[$];
    logic [BITS-1:0] exp_next;
    logic            prev_rsp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Every accepted read enqueues the response the stimulus expects.
    always @(posedge clk) begin
        if (rst_n && bus.req_valid && bus.req_ready) begin
            n_acc++;
            if (!bus.req_write) sb_q.push_back(exp_next);
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rsp = 1'b0;
        end else begin
            if (bus.rsp_valid) begin
                n_rsp++;
                check("rsp_pulse", {31'd0, prev_rsp}, 32'd0);
                if (sb_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
                else check("rsp_data", {16'd0, bus.rsp_data}, {16'd0, sb_q.pop_front()});
            end
            prev_rsp = bus.rsp_valid;
        end
    end

    task automatic do_write(input logic [BITS-1:0] data, input int turn);
        check("wr_ready", {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_data  = data;
        @(posedge clk);
        for (int c = 1; c <= turn + 3; c++) begin
            @(negedge clk);
            if (c == 1) bus.req_valid = 1'b0;
            if (c <= turn) begin
                check("wr_turn_en", {31'd0, bus.io_en}, 32'd0);
                check("wr_turn_dir", {31'd0, bus.io_dir}, 32'd0);
                check("wr_turn_busy", {31'd0, bus.busy}, 32'd1);
            end else if (c <= turn + 2) begin
                check("wr_en", {31'd0, bus.io_en}, 32'd1);
                check("wr_dir", {31'd0, bus.io_dir}, 32'd1);
                check("wr_data", {16'd0, bus.io_wdata}, {16'd0, data});
            end else begin
                check("wr_ready_after", {31'd0, bus.req_ready}, 32'd1);
                check("wr_idle_en", {31'd0, bus.io_en}, 32'd0);
                check("wr_idle_dir", {31'd0, bus.io_dir}, 32'd1);
                check("wr_hold_data", {16'd0, bus.io_wdata}, {16'd0, data});
            end
        end
    endtask

    task automatic do_read(input logic [BITS-1:0] s0, input logic [BITS-1:0] s1,
                           input logic [BITS-1:0] s2, input logic [BITS-1:0] s3,
                           input int turn);
        logic [BITS-1:0] s[4];
        logic [BITS+1:0] sum;
        int lat;
        int k;
        bit seen;
        s   = '{s0, s1, s2, s3};
        sum = {2'b00, s0} + {2'b00, s1} + {2'b00, s2} + {2'b00, s3};
`ifdef IO_SEQ_AVG_EN
        exp_next = sum[BITS+1:2];
`else
        exp_next = s0;
`endif
        lat = SETTLE + 3 + turn + AVG_EXTRA;
        check("rd_ready", {31'd0, bus.req_ready}, 32'd1);
        bus.io_rdata  = s0;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        @(posedge clk);
        seen = 0;
        for (int c = 1; c <= lat + 4 && !seen; c++) begin
            @(negedge clk);
            if (c == 1) bus.req_valid = 1'b0;
            if (turn != 0 && c == 1) begin
                check("rd_turn_en", {31'd0, bus.io_en}, 32'd0);
                check("rd_turn_dir", {31'd0, bus.io_dir}, 32'd1);
            end
            if (c == turn + 1) begin
                check("rd_en", {31'd0, bus.io_en}, 32'd1);
                check("rd_dir", {31'd0, bus.io_dir}, 32'd0);
            end
            k = c - (SETTLE + 2 + turn);
            if (k >= 0 && k < N_AVG) bus.io_rdata = s[k];
            if (bus.rsp_valid) begin
                seen = 1;
                check("rd_latency", c, lat);
            end
        end
        if (!seen) check("rd_timeout", 32'd0, 32'd1);
        @(negedge clk);
        check("rd_ready_after", {31'd0, bus.req_ready}, 32'd1);
        check("rd_rsp_hold", {16'd0, bus.rsp_data}, {16'd0, exp_next});
    endtask

    initial begin
        int acc0;
        int rsp0;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_data  = '0;
        bus.io_rdata  = '0;
        exp_next      = '0;
        prev_rsp      = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_en", {31'd0, bus.io_en}, 32'd0);
        check("rst_dir", {31'd0, bus.io_dir}, 32'd0);
        check("rst_wdata", {16'd0, bus.io_wdata}, 32'd0);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_rsp_data", {16'd0, bus.rsp_data}, 32'd0);

        do_write(16'hA5A5, 1);
        do_write(16'h1234, 0);
        do_read(16'h1234, 16'h1234, 16'h1234, 16'h1234, 1);
        do_read(16'h0001, 16'h0001, 16'h0001, 16'h0001, 0);
        do_read(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0);
        do_read(16'hFFFF, 16'hFFFF, 16'hFFFD, 16'hFFFD, 0);

        // Request held across busy periods: one accept per IDLE entry.
        acc0          = n_acc;
        rsp0          = n_rsp;
        bus.io_rdata  = 16'h5A5A;
        exp_next      = 16'h5A5A;
        bus.req_write = 1'b0;
        bus.req_valid = 1'b1;
        repeat (3 * PERIOD_RD) @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (PERIOD_RD) @(negedge clk);
        check("held_accepts", n_acc - acc0, 32'd3);
        check("held_responses", n_rsp - rsp0, 32'd3);

        // Reset in the middle of a read discards it.
        do_write(16'h0F0F, 1);
        bus.io_rdata  = 16'h7777;
        exp_next      = 16'h7777;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_in_read", {31'd0, bus.io_en}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, bus.busy}, 32'd0);
        check("arst_en", {31'd0, bus.io_en}, 32'd0);
        check("arst_dir", {31'd0, bus.io_dir}, 32'd0);
        check("arst_wdata", {16'd0, bus.io_wdata}, 32'd0);
        check("arst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("arst_rsp_data", {16'd0, bus.rsp_data}, 32'd0);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("arst_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        do_read(16'h3C3C, 16'h3C3C, 16'h3C3C, 16'h3C3C, 0);
        do_write(16'hC3C3, 1);

        repeat (2) @(negedge clk);
        check("sb_empty", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
